// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM skid stage: NZCV bit positions, the
// default-width entry layout and the occupancy encoding.
package ex_mem_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_SDATA_W = 8;
   localparam int DEF_RADDR_W = 3;
   localparam int DEF_LANES   = 2;

   // Field order matches the stage's internal slot layout, MSB first.
   typedef struct packed {
      logic [DEF_DATA_W-1:0]            alu;
      logic [DEF_DATA_W-1:0]            addr;
      logic [DEF_SDATA_W-1:0]           sdata;
      logic                             mem_rd;
      logic                             mem_wr;
      logic [DEF_LANES*DEF_RADDR_W-1:0] rd;
      logic [DEF_LANES-1:0]             we;
      logic [3:0]                       flags;
      logic [DEF_LANES*4-1:0]           flag_we;
   } entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

endpackage

// File: rtl/ex_mem_skid2_slot.sv
// One skid-buffer slot: a payload register with load enable plus a valid bit,
// both cleared by the asynchronous active-low reset.
module skid2_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // NOTE: payload is reset too, so held data after reset reads as zero;
   // non-blocking assignments keep both registers sampling pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         if (load_i) data_q <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating downstream-stall counter.
module ex_mem_skid
   import ex_mem_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SDATA_W = 8,
   parameter int RADDR_W = 3,
   parameter int LANES   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_alu,
   input  logic [DATA_W-1:0]        in_addr,
   input  logic [SDATA_W-1:0]       in_sdata,
   input  logic                     in_mem_rd,
   input  logic                     in_mem_wr,
   input  logic [LANES*RADDR_W-1:0] in_rd,
   input  logic [LANES-1:0]         in_we,
   input  logic [3:0]               in_flags,
   input  logic [LANES*4-1:0]       in_flag_we,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_alu,
   output logic [DATA_W-1:0]        out_addr,
   output logic [SDATA_W-1:0]       out_sdata,
   output logic                     out_mem_rd,
   output logic                     out_mem_wr,
   output logic [LANES*RADDR_W-1:0] out_rd,
   output logic [LANES-1:0]         out_we,
   output logic [3:0]               out_flags,
   output logic [LANES*4-1:0]       out_flag_we,
   output logic [1:0]               occupancy,
   output logic [CNT_W-1:0]         stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0]        alu;
      logic [DATA_W-1:0]        addr;
      logic [SDATA_W-1:0]       sdata;
      logic                     mem_rd;
      logic                     mem_wr;
      logic [LANES*RADDR_W-1:0] rd;
      logic [LANES-1:0]         we;
      logic [3:0]               flags;
      logic [LANES*4-1:0]       flag_we;
   } slot_t;

   slot_t            in_ent, main_ent, skid_ent, main_d;
   logic             main_v, skid_v, main_vd, skid_vd, main_ld, skid_ld;
   logic             push, pop;
   logic [CNT_W-1:0] stall_q, stall_d;
   occ_e             occ;

   assign in_ent = '{alu: in_alu, addr: in_addr, sdata: in_sdata,
                     mem_rd: in_mem_rd, mem_wr: in_mem_wr, rd: in_rd,
                     we: in_we, flags: in_flags, flag_we: in_flag_we};

   // in_ready depends only on registered SKID state, never on out_ready.
   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign push      = in_valid & in_ready;
   assign pop       = main_v & out_ready;

   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      main_vd = main_v;
      skid_vd = skid_v;
      main_ld = 1'b0;
      skid_ld = 1'b0;
      main_d  = in_ent;
      if (flush) begin
         main_vd = 1'b0;
         skid_vd = 1'b0;
      end else if (pop && skid_v) begin
         main_vd = 1'b1;
         main_ld = 1'b1;
         main_d  = skid_ent;
         skid_vd = 1'b0;
      end else if (push && (!main_v || pop)) begin
         main_vd = 1'b1;
         main_ld = 1'b1;
      end else if (push) begin
         skid_vd = 1'b1;
         skid_ld = 1'b1;
      end else if (pop) begin
         main_vd = 1'b0;
      end
   end

   skid2_slot #(.W($bits(slot_t))) u_main (
      .clk(clk), .rst_n(reset), .valid_i(main_vd), .load_i(main_ld),
      .data_i(main_d), .valid_o(main_v), .data_o(main_ent)
   );

   skid2_slot #(.W($bits(slot_t))) u_skid (
      .clk(clk), .rst_n(reset), .valid_i(skid_vd), .load_i(skid_ld),
      .data_i(in_ent), .valid_o(skid_v), .data_o(skid_ent)
   );

   always_comb begin
      stall_d = stall_q;
      if (main_v && !out_ready && !(&stall_q)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   // SKID is only ever filled behind a valid MAIN.
   always_comb begin
      occ = OCC_EMPTY;
      if (skid_v)      occ = OCC_FULL;
      else if (main_v) occ = OCC_ONE;
   end

   assign occupancy   = occ;
   assign stall_cnt   = stall_q;
   assign out_alu     = main_ent.alu;
   assign out_addr    = main_ent.addr;
   assign out_sdata   = main_ent.sdata;
   assign out_rd      = main_ent.rd;
   assign out_flags   = main_ent.flags;
   assign out_mem_rd  = main_ent.mem_rd & main_v;
   assign out_mem_wr  = main_ent.mem_wr & main_v;
   assign out_we      = main_ent.we & {LANES{main_v}};
   assign out_flag_we = main_ent.flag_we & {(LANES*4){main_v}};

endmodule

// File: tb/tb_ex_mem_skid.sv
// Randomized scoreboard bench for ex_mem_skid: accepted entries are queued,
// a monitor compares the presented entry, handshake state and stall counter.
module tb_ex_mem_skid;
   import ex_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_alu, in_addr, out_alu, out_addr;
   logic [7:0]  in_sdata, out_sdata, in_flag_we, out_flag_we;
   logic        in_mem_rd, in_mem_wr, out_mem_rd, out_mem_wr;
   logic [5:0]  in_rd, out_rd;
   logic [1:0]  in_we, out_we, occupancy;
   logic [3:0]  in_flags, out_flags;
   logic [15:0] stall_cnt;

   logic        sat_in_valid, sat_in_ready, sat_out_valid, sat_mem_rd, sat_mem_wr;
   logic [31:0] sat_alu, sat_addr;
   logic [7:0]  sat_sdata, sat_flag_we;
   logic [5:0]  sat_rd;
   logic [1:0]  sat_we, sat_occ;
   logic [3:0]  sat_flags;
   logic [2:0]  sat_stall;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic        mon_en = 1'b0;
   entry_t      exp_q[$];
   entry_t      last_ent = '0;
   entry_t      acc_e;
   logic        acc = 1'b0;
   logic [15:0] stall_m = '0;

   always #5 clk = ~clk;

   ex_mem_skid u_dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu(in_alu), .in_addr(in_addr), .in_sdata(in_sdata), .in_mem_rd(in_mem_rd),
      .in_mem_wr(in_mem_wr), .in_rd(in_rd), .in_we(in_we), .in_flags(in_flags),
      .in_flag_we(in_flag_we), .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_addr(out_addr), .out_sdata(out_sdata),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_rd(out_rd), .out_we(out_we),
      .out_flags(out_flags), .out_flag_we(out_flag_we), .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   ex_mem_skid #(.CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .flush(1'b0), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
      .in_alu(32'h5), .in_addr(32'h0), .in_sdata(8'h0), .in_mem_rd(1'b0),
      .in_mem_wr(1'b0), .in_rd(6'h0), .in_we(2'b0), .in_flags(4'h0),
      .in_flag_we(8'h0), .out_valid(sat_out_valid), .out_ready(1'b0),
      .out_alu(sat_alu), .out_addr(sat_addr), .out_sdata(sat_sdata),
      .out_mem_rd(sat_mem_rd), .out_mem_wr(sat_mem_wr), .out_rd(sat_rd), .out_we(sat_we),
      .out_flags(sat_flags), .out_flag_we(sat_flag_we), .occupancy(sat_occ),
      .stall_cnt(sat_stall)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic entry_t rand_ent();
      entry_t e;
      e.alu     = $urandom;
      e.addr    = $urandom;
      e.sdata   = 8'($urandom);
      e.mem_rd  = 1'($urandom);
      e.mem_wr  = 1'($urandom);
      e.rd      = 6'($urandom);
      e.we      = 2'($urandom);
      e.flags   = 4'($urandom);
      e.flag_we = 8'($urandom);
      return e;
   endfunction

   // One cycle of stimulus, applied just after the active edge.
   task automatic drive(input logic v, input entry_t e, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      in_valid   = v;
      in_alu     = e.alu;
      in_addr    = e.addr;
      in_sdata   = e.sdata;
      in_mem_rd  = e.mem_rd;
      in_mem_wr  = e.mem_wr;
      in_rd      = e.rd;
      in_we      = e.we;
      in_flags   = e.flags;
      in_flag_we = e.flag_we;
      out_ready  = rdy;
      flush      = fl;
   endtask

   // Stimulus side: an entry accepted this cycle joins the expected queue at the edge.
   always @(negedge clk) begin
      acc = mon_en && in_valid && in_ready && !flush;
      acc_e = '{alu: in_alu, addr: in_addr, sdata: in_sdata, mem_rd: in_mem_rd,
                mem_wr: in_mem_wr, rd: in_rd, we: in_we, flags: in_flags, flag_we: in_flag_we};
   end

   always @(posedge clk) begin
      if (acc && mon_en) exp_q.push_back(acc_e);
   end

   // Monitor: compares against the queue mid-cycle, then retires by the handshake rules.
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         check("occupancy", 64'(occupancy), 64'(exp_q.size()));
         check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
         if (exp_q.size() > 0) begin
            last_ent = exp_q[0];
            check("out_alu", 64'(out_alu), 64'(last_ent.alu));
            check("out_addr", 64'(out_addr), 64'(last_ent.addr));
            check("out_sdata", 64'(out_sdata), 64'(last_ent.sdata));
            check("out_mem_rd", 64'(out_mem_rd), 64'(last_ent.mem_rd));
            check("out_mem_wr", 64'(out_mem_wr), 64'(last_ent.mem_wr));
            check("out_rd", 64'(out_rd), 64'(last_ent.rd));
            check("out_we", 64'(out_we), 64'(last_ent.we));
            check("out_flags", 64'(out_flags), 64'(last_ent.flags));
            check("out_flag_we", 64'(out_flag_we), 64'(last_ent.flag_we));
         end else begin
            check("held_alu", 64'(out_alu), 64'(last_ent.alu));
            check("held_addr", 64'(out_addr), 64'(last_ent.addr));
            check("held_rd", 64'(out_rd), 64'(last_ent.rd));
            check("idle_mem_rd", 64'(out_mem_rd), 64'd0);
            check("idle_mem_wr", 64'(out_mem_wr), 64'd0);
            check("idle_we", 64'(out_we), 64'd0);
            check("idle_flag_we", 64'(out_flag_we), 64'd0);
         end
         if (exp_q.size() > 0 && !out_ready && stall_m != 16'hFFFF) stall_m++;
         if (flush) exp_q.delete();
         else if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      end
   end

   // Narrow counter instance: one entry held forever must pin stall_cnt at 7.
   initial begin
      sat_in_valid = 1'b0;
      #26 sat_in_valid = 1'b1;
      #10 sat_in_valid = 1'b0;
      #40 check("sat_stall_mid", 64'(sat_stall), 64'd4);
      #80 check("sat_stall_max", 64'(sat_stall), 64'd7);
   end

   initial begin
      entry_t e;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu = '0; in_addr = '0; in_sdata = '0; in_mem_rd = 1'b0; in_mem_wr = 1'b0;
      in_rd = '0; in_we = '0; in_flags = '0; in_flag_we = '0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("rst_out_alu", 64'(out_alu), 64'd0);
      #20 reset = 1'b1;
      mon_en = 1'b1;

      for (int i = 1; i <= 3; i++) begin
         e = rand_ent();
         e.alu = 32'(i);
         drive(1'b1, e, 1'b1, 1'b0);
      end
      repeat (3) drive(1'b0, rand_ent(), 1'b1, 1'b0);

      e = rand_ent(); e.alu = 32'hA; drive(1'b1, e, 1'b0, 1'b0);
      e = rand_ent(); e.alu = 32'hB; drive(1'b1, e, 1'b0, 1'b0);
      repeat (3) drive(1'b1, rand_ent(), 1'b0, 1'b0);
      repeat (3) drive(1'b0, rand_ent(), 1'b1, 1'b0);

      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      repeat (5) drive(1'b0, rand_ent(), 1'b0, 1'b0);
      drive(1'b0, rand_ent(), 1'b1, 1'b0);

      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      drive(1'b1, rand_ent(), 1'b0, 1'b1);
      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      drive(1'b1, rand_ent(), 1'b1, 1'b1);
      repeat (3) drive(1'b0, rand_ent(), 1'b1, 1'b0);

      e = rand_ent(); e.we = 2'b10; e.flag_we = 8'hF0; e.mem_wr = 1'b1;
      drive(1'b1, e, 1'b1, 1'b0);
      repeat (3) drive(1'b0, rand_ent(), 1'b1, 1'b0);

      repeat (400)
         drive($urandom_range(0, 9) < 7, rand_ent(), $urandom_range(0, 9) < 6,
               $urandom_range(0, 31) == 0);

      drive(1'b0, rand_ent(), 1'b1, 1'b0);
      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      drive(1'b1, rand_ent(), 1'b0, 1'b0);
      drive(1'b0, rand_ent(), 1'b1, 1'b0);
      #2;
      reset  = 1'b0;
      mon_en = 1'b0;
      #1;
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_occupancy", 64'(occupancy), 64'd0);
      check("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      check("arst_out_alu", 64'(out_alu), 64'd0);
      check("arst_out_we", 64'(out_we), 64'd0);
      check("arst_out_mem_wr", 64'(out_mem_wr), 64'd0);
      exp_q.delete();
      stall_m  = '0;
      last_ent = '0;
      out_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      drive(1'b1, rand_ent(), 1'b1, 1'b0);
      repeat (4) drive(1'b0, rand_ent(), 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
